// File: rtl/max_reduce_int64_pkg.sv
// Shared types and default sizes for the streaming signed max reduction.
// The FSM encoding lives here so the bench and any bound checkers can decode dbg_state.
package max_reduce_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_IDX_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/max_reduce_int64_if.sv
// Element stream in, single result beat out.
// Both channels use valid/ready: a beat transfers on a rising edge where valid and ready are
// both high; once valid is raised its payload holds until that transfer happens.
interface max_reduce_int64_if #(
   parameter int WIDTH = max_reduce_pkg::DEF_WIDTH,
   parameter int IDX_W = max_reduce_pkg::DEF_IDX_W
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [IDX_W-1:0] out_idx;
   logic [IDX_W-1:0] out_cnt;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_max, out_idx, out_cnt
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_max, out_idx, out_cnt
   );

endinterface

// File: rtl/max_reduce_int64_gt_int_nbit.sv
// Pairwise signed greater-than: y = (a > b) with both operands two's complement.
// Shared with the pairwise max stage so both agree on compare semantics.
module gt_int_nbit #(
   parameter int N = 64
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         y
);

   assign y = $signed(a) > $signed(b);

endmodule

// File: rtl/max_reduce_int64.sv
// Streaming signed max reduction: running max + earliest argmax + element count,
// emitted as one result beat on the element flagged last.
module max_reduce_int64
   import max_reduce_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int IDX_W = DEF_IDX_W
) (
   input  logic                clk,
   input  logic                rst_n,
   max_reduce_int64_if.slave   bus,
   output state_t              dbg_state
);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] max_r;
   logic [IDX_W-1:0] idx_r;
   logic [IDX_W-1:0] cnt_r;
   logic             in_ready_c;
   logic             accept;
   logic             replace;

   // Strict greater-than: a tie keeps the earlier index.
   gt_int_nbit #(
      .N (WIDTH)
   ) u_gt (
      .a (bus.in_data),
      .b (max_r),
      .y (replace)
   );

   assign in_ready_c = (state != ST_DONE);
   assign accept     = bus.in_valid && in_ready_c;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_ACCUM: begin
            if (accept) begin
               state_nxt = bus.in_last ? ST_DONE : ST_ACCUM;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The first element of a vector seeds the registers; later ones only replace on a strict win.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         max_r <= '0;
         idx_r <= '0;
         cnt_r <= '0;
      end else if (accept) begin
         if (state == ST_IDLE) begin
            max_r <= bus.in_data;
            idx_r <= '0;
            cnt_r <= IDX_W'(1);
         end else begin
            if (replace) begin
               max_r <= bus.in_data;
               idx_r <= cnt_r;
            end
            cnt_r <= cnt_r + IDX_W'(1);
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = (state == ST_DONE);
   assign bus.out_max   = max_r;
   assign bus.out_idx   = idx_r;
   assign bus.out_cnt   = cnt_r;
   assign dbg_state     = state;

endmodule

// File: tb/tb_max_reduce_int64.sv
// Bench for max_reduce_int64: directed vectors from the test plan plus randomized vectors,
// scored against a queue-based reference of (max, first argmax, count).
module tb_max_reduce_int64;
   import max_reduce_pkg::*;

   localparam int W  = 64;
   localparam int IW = 16;
   localparam int RW = W + 2 * IW;

   logic   clk;
   logic   rst_n;
   state_t dbg_state;

   max_reduce_int64_if #(.WIDTH(W), .IDX_W(IW)) bus ();

   max_reduce_int64 #(.WIDTH(W), .IDX_W(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [RW-1:0] exp_q[$];
   logic [W-1:0]  cur_vec[$];
   logic          rand_ready = 1'b0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: max over all elements, then first position holding it.
   function automatic logic [RW-1:0] model();
      logic signed [W-1:0] m;
      logic [IW-1:0]       idx;
      m = cur_vec[0];
      foreach (cur_vec[i]) if ($signed(cur_vec[i]) > m) m = cur_vec[i];
      idx = '0;
      for (int i = cur_vec.size() - 1; i >= 0; i--) if (cur_vec[i] == m) idx = IW'(i);
      return {m, idx, IW'(cur_vec.size())};
   endfunction

   task automatic send_vec(input int bubble_pct);
      int budget;
      exp_q.push_back(model());
      for (int i = 0; i < cur_vec.size(); i++) begin
         while ($urandom_range(0, 99) < bubble_pct) begin
            bus.in_valid = 1'b0;
            bus.in_data  = {$urandom, $urandom};
            bus.in_last  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = cur_vec[i];
         bus.in_last  = (i == cur_vec.size() - 1);
         budget = 0;
         while (!bus.in_ready && budget < 200) begin
            @(posedge clk); #1;
            budget++;
         end
         if (budget >= 200) begin
            check("in_ready_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_data  = {$urandom, $urandom};
      check("latency_out_valid", W'(bus.out_valid), 1);
   endtask

   task automatic wait_idle();
      int budget = 0;
      while (!bus.in_ready && budget < 300) begin
         @(posedge clk); #1;
         budget++;
      end
      if (budget >= 300) check("idle_timeout", 0, 1);
   endtask

   // scoreboard / monitor, sampled on the falling edge
   logic          hold_valid = 1'b0;
   logic [RW-1:0] hold_val;
   logic [RW-1:0] e;

   always @(negedge clk) begin
      if (rst_n && bus.out_valid) begin
         if (hold_valid) begin
            check("stall_stable_max", bus.out_max, hold_val[RW-1 -: W]);
            check("stall_stable_idx", W'(bus.out_idx), W'(hold_val[2*IW-1 -: IW]));
            check("stall_stable_cnt", W'(bus.out_cnt), W'(hold_val[IW-1:0]));
         end
         if (bus.out_ready) begin
            hold_valid = 1'b0;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_max", bus.out_max, e[RW-1 -: W]);
               check("out_idx", W'(bus.out_idx), W'(e[2*IW-1 -: IW]));
               check("out_cnt", W'(bus.out_cnt), W'(e[IW-1:0]));
            end
         end else begin
            hold_valid = 1'b1;
            hold_val   = {bus.out_max, bus.out_idx, bus.out_cnt};
         end
      end else begin
         hold_valid = 1'b0;
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int t;
      int len;
      int budget;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", W'(bus.out_valid), 0);
      check("rst_out_max", bus.out_max, 0);
      check("rst_out_idx", W'(bus.out_idx), 0);
      check("rst_out_cnt", W'(bus.out_cnt), 0);
      check("rst_state", W'(dbg_state), W'(ST_IDLE));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", W'(bus.in_ready), 1);

      // basic vector
      cur_vec = '{64'd5, -64'sd3, 64'd12, 64'd7};
      send_vec(0);
      wait_idle();

      // all negatives with a tie and the most negative value
      cur_vec = '{-64'sd1, -64'sd9, 64'h8000_0000_0000_0000, -64'sd1};
      send_vec(0);
      wait_idle();

      // single element at the positive extreme
      cur_vec = '{64'h7FFF_FFFF_FFFF_FFFF};
      send_vec(0);
      wait_idle();

      // result back-pressure
      bus.out_ready = 1'b0;
      cur_vec = '{64'd10, -64'sd4};
      send_vec(0);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = 64'd999;
         bus.in_last  = 1'b1;
         check("bp_out_valid", W'(bus.out_valid), 1);
         check("bp_in_ready", W'(bus.in_ready), 0);
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", W'(bus.out_valid), 0);
      check("bp_release_ready", W'(bus.in_ready), 1);
      cur_vec = '{64'd2, 64'd3};
      send_vec(0);
      wait_idle();

      // input bubbles
      cur_vec = '{64'd4, 64'd4, 64'd9, 64'd1};
      send_vec(50);
      wait_idle();

      // reset mid-vector discards partial state
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_last = 1'b0; bus.in_data = 64'd100;
      @(posedge clk); #1;
      bus.in_data = 64'd200;
      @(posedge clk); #1;
      bus.in_data = 64'd300;
      bus.in_last = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      check("midrst_out_valid", W'(bus.out_valid), 0);
      check("midrst_out_max", bus.out_max, 0);
      check("midrst_out_idx", W'(bus.out_idx), 0);
      check("midrst_out_cnt", W'(bus.out_cnt), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_in_ready", W'(bus.in_ready), 1);
      cur_vec = '{-64'sd5};
      send_vec(0);
      wait_idle();

      // randomized vectors with random bubbles and result stalls
      rand_ready = 1'b1;
      for (int v = 0; v < 30; v++) begin
         cur_vec.delete();
         len = $urandom_range(1, 9);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               t = $urandom_range(0, 6);
               cur_vec.push_back(64'(t - 3));
            end else begin
               cur_vec.push_back({$urandom, $urandom});
            end
         end
         send_vec($urandom_range(0, 40));
      end
      rand_ready = 1'b0;
      @(posedge clk); #2;
      bus.out_ready = 1'b1;

      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin
         @(posedge clk); #1;
         budget++;
      end
      check("drain_exp_q", W'(exp_q.size()), 0);
      @(posedge clk); #1;
      check("end_state", W'(dbg_state), W'(ST_IDLE));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
